sudoku_cell_fetch: RTL and testbench
====================================

# sudoku_cell_fetch

Board-state store and pixel-to-cell lookup stage sitting directly upstream of the number pixel generator in the VGA path. It holds the 81 Sudoku cells written by the recognizer/solver side through a valid/ready port. For every pixel coordinate from the VGA controller it produces the cell index and the 11-bit cell word the pixel generator renders, pipelined and aligned with delayed counters. A clear sequencer wipes the board on request.

## Interface
- CELL, 52, cell edge in pixels
- GRID, 9, cells per row/column (board = GRID*CELL = 468 px square, origin at h=0, v=0)
- clk  in  1  pixel clock, all logic rising-edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- h_cnt  in  10  horizontal pixel counter from VGA controller
- v_cnt  in  10  vertical pixel counter from VGA controller
- wr_valid  in  1  cell write request
- wr_ready  out  1  write port can accept
- wr_index  in  7  target cell, row*9+col, 0..80
- wr_value  in  4  digit 0..9, 0 = empty
- wr_given  in  1  cell is a puzzle clue (not solver-filled)
- clr_req  in  1  single-cycle pulse, start board clear
- cursor_index  in  7  highlighted cell; 127 = none
- busy  out  1  clear sequence running
- wr_err  out  1  sticky: a write with wr_index > 80 was accepted
- index_out  out  10  cell index of delayed pixel, 0..80
- number_out  out  11  cell word: [3:0] value, [4] given, [5] cursor, [10:6] zero
- cell_valid  out  1  delayed pixel lies inside the board
- h_cnt_d  out  10  h_cnt delayed 2 cycles
- v_cnt_d  out  10  v_cnt delayed 2 cycles

## Operation
- Storage: 81 entries × 5 bits (value, given). Reset clears all entries to 0.
- Write port: transfer when wr_valid && wr_ready at a rising edge. wr_index ≤ 80 → entry updated next edge. wr_index > 80 → accepted, discarded, wr_err set.
- wr_ready = (state == IDLE), combinational from state.
- FSM states: IDLE, CLEAR.
  - IDLE → CLEAR on clr_req; clear counter loaded with 0.
  - CLEAR: writes entry[counter] = 0 each cycle, counter 0→80; after writing 80 → IDLE. Exactly 81 cycles in CLEAR.
  - clr_req during CLEAR restarts the counter at 0; the sequence is another full 81 cycles.
  - wr_err cleared when CLEAR is entered.
- Lookup pipeline, stage 1 (registered): col = floor(h_cnt/CELL) and row = floor(v_cnt/CELL) via comparator chain against multiples of CELL. No divider. in_board = h_cnt < 468 && v_cnt < 468. Counters registered.
- Lookup stage 2 (registered): idx = row*9 + col (shift-add). Reads entry[idx]. cursor bit = (idx == cursor_index). Outputs registered.
- Outside the board: cell_valid=0, index_out=0, number_out=0. h_cnt_d/v_cnt_d still track.
- cursor_index is sampled in stage 2. Values 81..127 never match.

## Timing
- Reset values: wr_ready=1, busy=0, wr_err=0, index_out=0, number_out=0, cell_valid=0, h_cnt_d=0, v_cnt_d=0, state IDLE.
- Lookup latency: 2 cycles, fixed, throughput 1 pixel/cycle, no stalls. Outputs at edge N+2 correspond to h_cnt/v_cnt sampled at edge N.
- Write→display: a write committed at edge W is visible for lookups whose stage-2 read occurs at edge W+1 or later. A stage-2 read at edge W returns the pre-write value.
- Clear: busy=1 from the edge after clr_req through the edge writing entry 80. wr_ready=0 for the same span. Display reads during clear show a partially cleared board (no blanking).
- Reset asserted mid-clear or mid-write: immediate return to reset values; board zeroed.
- Cell boundaries: h=51 → col 0, h=52 → col 1, h=467 → col 8, h=468 → outside.

## Test plan
- Reset, then apply h=0,v=0 → after 2 cycles: cell_valid=1, index_out=0, number_out=0, h_cnt_d=0.
- Write idx 40, value 7, given=1; probe h=230, v=230 → index_out=40, number_out=11'h017. With cursor_index=40 → 11'h037.
- Boundary sweep: h=51/52/467/468 at v=0 → index_out 0/1/8; at h=468, cell_valid=0 and number_out=0.
- Write wr_index=100 → wr_ready=1, no entry changes, wr_err=1. A following clr_req clears wr_err.
- Fill all 81 cells with 5, pulse clr_req → busy high exactly 81 cycles, wr_ready=0 throughout, all lookups return 0 afterwards. A second clr_req at clear cycle 40 extends busy to 40+81 cycles.
- Write idx 0 at the same edge as the stage-2 read of idx 0 → old value output; next pixel of idx 0 shows the new value.

Source files
------------

// File: rtl/sudoku_cell_fetch_if.sv
// Sudoku board write port: valid/ready transfer of one cell
// (index, digit, clue flag) from the recognizer/solver side.
interface sudoku_cell_fetch_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [6:0] wr_index;
  logic [3:0] wr_value;
  logic       wr_given;

  modport master (
    output wr_valid, wr_index, wr_value, wr_given,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_index, wr_value, wr_given,
    output wr_ready
  );
endinterface

// File: rtl/sudoku_cell_fetch.sv
// Sudoku board store plus 2-stage pixel-to-cell lookup for the VGA path,
// with a sequential board-clear engine.
module sudoku_cell_fetch #(
  parameter int CELL = 52,
  parameter int GRID = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  sudoku_cell_fetch_if.slave wr,
  input  logic [9:0]  i_h_cnt,
  input  logic [9:0]  i_v_cnt,
  input  logic        i_clr_req,
  input  logic [6:0]  i_cursor_index,
  output logic        o_busy,
  output logic        o_wr_err,
  output logic [9:0]  o_index_out,
  output logic [10:0] o_number_out,
  output logic        o_cell_valid,
  output logic [9:0]  o_h_cnt_d,
  output logic [9:0]  o_v_cnt_d
);

  localparam int NCELL = GRID * GRID;
  localparam int BOARD = GRID * CELL;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      r_state, w_state_nx;
  logic [6:0]  r_clr_cnt, w_clr_cnt_nx;
  logic [4:0]  r_mem [NCELL];
  logic        r_wr_err;
  logic        w_wr_fire, w_wr_ok;

  logic [3:0]  w_col, w_row;
  logic [3:0]  r_col, r_row;
  logic        r_in1;
  logic [9:0]  r_h1, r_v1;
  logic [6:0]  w_idx;
  logic [4:0]  w_rd;

  logic        r_valid;
  logic [9:0]  r_index;
  logic [10:0] r_number;
  logic [9:0]  r_hd, r_vd;

  // Comparator chain: highest multiple of CELL not above p.
  function automatic logic [3:0] f_cell(input logic [9:0] p);
    f_cell = '0;
    for (int k = 1; k < GRID; k++)
      if (p >= 10'(k * CELL)) f_cell = 4'(k);
  endfunction

  always_comb begin
    w_state_nx   = r_state;
    w_clr_cnt_nx = r_clr_cnt;
    unique case (r_state)
      IDLE: begin
        if (i_clr_req) begin
          w_state_nx   = CLEAR;
          w_clr_cnt_nx = '0;
        end
      end
      CLEAR: begin
        if (i_clr_req)
          w_clr_cnt_nx = '0;
        else if (r_clr_cnt == 7'(NCELL - 1))
          w_state_nx = IDLE;
        else
          w_clr_cnt_nx = r_clr_cnt + 7'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_clr_cnt <= w_clr_cnt_nx;
    end
  end

  assign wr.wr_ready = (r_state == IDLE);
  assign o_busy      = (r_state == CLEAR);
  assign w_wr_fire   = wr.wr_valid && wr.wr_ready;
  assign w_wr_ok     = (wr.wr_index <= 7'(NCELL - 1));

  // A clear request always wins over a bad write in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_wr_err <= 1'b0;
    else if (i_clr_req)
      r_wr_err <= 1'b0;
    else if (w_wr_fire && !w_wr_ok)
      r_wr_err <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCELL; i++) r_mem[i] <= '0;
    end else if (r_state == CLEAR) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_wr_fire && w_wr_ok) begin
      r_mem[wr.wr_index] <= {wr.wr_given, wr.wr_value};
    end
  end

  assign w_col = f_cell(i_h_cnt);
  assign w_row = f_cell(i_v_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
      r_in1 <= 1'b0;
      r_h1  <= '0;
      r_v1  <= '0;
    end else begin
      r_col <= w_col;
      r_row <= w_row;
      r_in1 <= (i_h_cnt < 10'(BOARD)) && (i_v_cnt < 10'(BOARD));
      r_h1  <= i_h_cnt;
      r_v1  <= i_v_cnt;
    end
  end

  // row*9 + col; the chain saturates at GRID-1 so idx never leaves the array.
  assign w_idx = {r_row, 3'b000} + {3'b000, r_row} + {3'b000, r_col};
  assign w_rd  = r_mem[w_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_index  <= '0;
      r_number <= '0;
      r_hd     <= '0;
      r_vd     <= '0;
    end else begin
      r_valid  <= r_in1;
      r_index  <= r_in1 ? {3'b000, w_idx} : '0;
      r_number <= r_in1 ? {5'b0, (w_idx == i_cursor_index), w_rd} : '0;
      r_hd     <= r_h1;
      r_vd     <= r_v1;
    end
  end

  assign o_wr_err     = r_wr_err;
  assign o_cell_valid = r_valid;
  assign o_index_out  = r_index;
  assign o_number_out = r_number;
  assign o_h_cnt_d    = r_hd;
  assign o_v_cnt_d    = r_vd;

endmodule

// File: tb/tb_sudoku_cell_fetch.sv
// Bench for sudoku_cell_fetch: directed steps plus random writes/pixels
// checked against a division-based board model.
module tb_sudoku_cell_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  h_cnt = '0, v_cnt = '0;
  logic        clr_req = 1'b0;
  logic [6:0]  cursor = 7'd127;
  logic        busy, wr_err, cell_valid;
  logic [9:0]  index_out, h_d, v_d;
  logic [10:0] number_out;

  sudoku_cell_fetch_if wif();

  sudoku_cell_fetch dut (
    .clk(clk), .rst_n(rst_n), .wr(wif),
    .i_h_cnt(h_cnt), .i_v_cnt(v_cnt),
    .i_clr_req(clr_req), .i_cursor_index(cursor),
    .o_busy(busy), .o_wr_err(wr_err),
    .o_index_out(index_out), .o_number_out(number_out),
    .o_cell_valid(cell_valid),
    .o_h_cnt_d(h_d), .o_v_cnt_d(v_d)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int board [81];
  bit m_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model;
    for (int i = 0; i < 81; i++) board[i] = 0;
  endtask

  task automatic do_write(input int idx, input int val, input bit g);
    wif.wr_valid = 1'b1;
    wif.wr_index = 7'(idx);
    wif.wr_value = 4'(val);
    wif.wr_given = g;
    chk("wr_ready_before_write", 32'(wif.wr_ready), 1);
    tick;
    wif.wr_valid = 1'b0;
    if (idx <= 80) board[idx] = val + (g ? 16 : 0);
    else m_err = 1'b1;
  endtask

  task automatic probe(input int h, input int v, input int cur);
    int in_b, idx, ei, en;
    h_cnt  = 10'(h);
    v_cnt  = 10'(v);
    cursor = 7'(cur);
    tick;
    tick;
    in_b = (h < 9 * 52 && v < 9 * 52) ? 1 : 0;
    idx  = (v / 52) * 9 + (h / 52);
    ei   = in_b ? idx : 0;
    en   = in_b ? board[idx] + ((idx == cur) ? 32 : 0) : 0;
    chk("cell_valid", 32'(cell_valid), in_b);
    chk("index_out", 32'(index_out), ei);
    chk("number_out", 32'(number_out), en);
    chk("h_cnt_d", 32'(h_d), h);
    chk("v_cnt_d", 32'(v_d), v);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 400) begin
      n++;
      tick;
    end
    chk(tag, 32'(busy), 0);
  endtask

  // Counts cycles spent busy; optionally re-requests clear on busy cycle 40.
  task automatic timed_clear(input bit restart, input int exp_cycles);
    int n = 0;
    bit rdy_ok = 1'b1;
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    while (busy && n < 400) begin
      n++;
      if (wif.wr_ready !== 1'b0) rdy_ok = 1'b0;
      clr_req = (restart && n == 40);
      tick;
    end
    clr_req = 1'b0;
    clear_model();
    chk("busy_cycles", 32'(n), 32'(exp_cycles));
    chk("wr_ready_low_during_clear", 32'(rdy_ok), 1);
    chk("wr_ready_after_clear", 32'(wif.wr_ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    wif.wr_valid = 1'b0;
    wif.wr_index = '0;
    wif.wr_value = '0;
    wif.wr_given = 1'b0;
    clear_model();
    tick;
    tick;
    chk("rst_wr_ready", 32'(wif.wr_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr_err", 32'(wr_err), 0);
    chk("rst_index", 32'(index_out), 0);
    chk("rst_number", 32'(number_out), 0);
    chk("rst_valid", 32'(cell_valid), 0);
    chk("rst_h_d", 32'(h_d), 0);
    chk("rst_v_d", 32'(v_d), 0);
    rst_n = 1'b1;
    tick;

    probe(0, 0, 127);

    do_write(40, 7, 1'b1);
    probe(230, 230, 127);
    chk("idx40_number", 32'(number_out), 32'h017);
    probe(230, 230, 40);
    chk("idx40_cursor", 32'(number_out), 32'h037);

    probe(51, 0, 127);
    chk("h51_col0", 32'(index_out), 0);
    probe(52, 0, 127);
    chk("h52_col1", 32'(index_out), 1);
    probe(467, 0, 127);
    chk("h467_col8", 32'(index_out), 8);
    probe(468, 0, 127);
    chk("h468_outside", 32'(cell_valid), 0);
    probe(0, 467, 72);
    probe(0, 468, 127);
    probe(467, 467, 80);

    do_write(100, 3, 1'b1);
    chk("bad_write_err", 32'(wr_err), 1);
    chk("bad_write_ready", 32'(wif.wr_ready), 1);
    probe(230, 230, 127);
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    chk("clr_clears_err", 32'(wr_err), 0);
    chk("clr_busy", 32'(busy), 1);
    wait_idle("clear_done_timeout");
    clear_model();
    probe(230, 230, 127);

    for (int i = 0; i < 60; i++)
      do_write($urandom_range(0, 80), $urandom_range(0, 9), 1'($urandom));
    for (int i = 0; i < 80; i++)
      probe($urandom_range(0, 639), $urandom_range(0, 479),
            $urandom_range(0, 127));

    for (int i = 0; i < 81; i++) do_write(i, 5, 1'b0);
    probe(26, 26, 127);
    timed_clear(1'b0, 81);
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        probe(c * 52 + 26, r * 52 + 26, 127);

    for (int i = 0; i < 81; i++) do_write(i, 5, 1'b0);
    timed_clear(1'b1, 121);
    for (int i = 0; i < 10; i++)
      probe($urandom_range(0, 467), $urandom_range(0, 467), 127);

    do_write(0, 3, 1'b0);
    h_cnt  = '0;
    v_cnt  = '0;
    cursor = 7'd127;
    tick;
    wif.wr_valid = 1'b1;
    wif.wr_index = 7'd0;
    wif.wr_value = 4'd9;
    wif.wr_given = 1'b1;
    tick;
    wif.wr_valid = 1'b0;
    chk("same_edge_old_value", 32'(number_out), 32'h003);
    tick;
    chk("next_pixel_new_value", 32'(number_out), 32'h019);
    board[0] = 9 + 16;

    do_write(10, 4, 1'b1);
    do_write(127, 1, 1'b0);
    chk("err_before_reset", 32'(wr_err), 1);
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    for (int i = 0; i < 9; i++) tick;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_ready", 32'(wif.wr_ready), 1);
    chk("async_rst_valid", 32'(cell_valid), 0);
    clear_model();
    tick;
    rst_n = 1'b1;
    tick;
    probe(26, 0, 127);
    probe(10 % 9 * 52 + 1, 52 + 1, 127);
    probe(300, 400, 127);

    do_write(55, 8, 1'b1);
    wif.wr_valid = 1'b1;
    wif.wr_index = 7'd56;
    wif.wr_value = 4'd2;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_write_err", 32'(wr_err), 0);
    wif.wr_valid = 1'b0;
    clear_model();
    tick;
    rst_n = 1'b1;
    tick;
    probe(1 * 52 + 5, 6 * 52 + 5, 127);
    probe(2 * 52 + 5, 6 * 52 + 5, 127);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
